// File: rtl/spi_slave_core_if.sv
// spi_slave_core_if: pin-side SPI signals plus the host-side TX/RX handshake of the slave core.
interface spi_slave_core_if #(parameter int CHAR_LEN = 8);
  logic                ss_n_in;
  logic                sclk_in;
  logic                mosi_in;
  logic                miso_out;
  logic                miso_oe;
  logic                cpol;
  logic                cpha;
  logic                lsb;
  logic [CHAR_LEN-1:0] tx_data;
  logic                tx_load;
  logic                tx_ready;
  logic [CHAR_LEN-1:0] rx_data;
  logic                rx_valid;
  logic                rx_ack;
  logic                overrun;
  logic                busy;
  modport slave (
    input  ss_n_in, sclk_in, mosi_in, cpol, cpha, lsb, tx_data, tx_load, rx_ack,
    output miso_out, miso_oe, tx_ready, rx_data, rx_valid, overrun, busy
  );
  modport master (
    output ss_n_in, sclk_in, mosi_in, cpol, cpha, lsb, tx_data, tx_load, rx_ack,
    input  miso_out, miso_oe, tx_ready, rx_data, rx_valid, overrun, busy
  );
endinterface

// File: rtl/spi_slave_core.sv
// spi_slave_core: oversampled SPI slave shift engine with single-entry TX buffer and RX holding register.
module spi_slave_core #(
  parameter int CHAR_LEN = 8,
  parameter int CNT_W    = 6
) (
  input logic             clk_in,
  input logic             rst,
  spi_slave_core_if.slave bus
);
  typedef enum logic {IDLE, ACTIVE} state_t;
  localparam logic [CHAR_LEN-1:0] ONE = CHAR_LEN'(1);
  localparam logic [CHAR_LEN-1:0] TOP = {1'b1, {(CHAR_LEN-1){1'b0}}};
  state_t              state_q, state_d;
  logic [2:0]          sclk_q;
  logic [1:0]          ss_q, mosi_q;
  logic                ss_prev_q;
  logic [CHAR_LEN-1:0] shift_q, shift_d, rx_q, rx_d, buf_q, buf_d, rx_data_q, rx_data_d;
  logic [CNT_W-1:0]    bit_q, bit_d, idx_q, idx_d;
  logic                tx_ready_q, tx_ready_d, rx_valid_q, rx_valid_d;
  logic                done_q, done_d, ovr_q, ovr_d;
  logic                active, sedge, lead, trail, sample, ss_fall, char_end, start;
  logic [CHAR_LEN-1:0] bit_mask, out_lsb, out_msb;
  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q    <= IDLE;
      sclk_q     <= '0;
      ss_q       <= '0;
      mosi_q     <= '0;
      ss_prev_q  <= 1'b0;
      shift_q    <= '0;
      rx_q       <= '0;
      buf_q      <= '0;
      rx_data_q  <= '0;
      bit_q      <= '0;
      idx_q      <= '0;
      tx_ready_q <= 1'b1;
      rx_valid_q <= 1'b0;
      done_q     <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      sclk_q     <= {sclk_q[1:0], bus.sclk_in};
      ss_q       <= {ss_q[0], bus.ss_n_in};
      mosi_q     <= {mosi_q[0], bus.mosi_in};
      ss_prev_q  <= ss_q[1];
      shift_q    <= shift_d;
      rx_q       <= rx_d;
      buf_q      <= buf_d;
      rx_data_q  <= rx_data_d;
      bit_q      <= bit_d;
      idx_q      <= idx_d;
      tx_ready_q <= tx_ready_d;
      rx_valid_q <= rx_valid_d;
      done_q     <= done_d;
      ovr_q      <= ovr_d;
    end
  end
  // Edges only count while selected; the sample edge is the trail edge when cpha=1.
  always_comb begin
    active   = state_q == ACTIVE;
    sedge    = active && (sclk_q[1] ^ sclk_q[2]);
    lead     = sedge && (sclk_q[1] != bus.cpol);
    trail    = sedge && (sclk_q[1] == bus.cpol);
    sample   = bus.cpha ? trail : lead;
    ss_fall  = ss_prev_q && !ss_q[1];
    char_end = trail && ((bit_q + CNT_W'(sample)) == CNT_W'(CHAR_LEN));
    start    = (!active && ss_fall) || (active && !ss_q[1] && char_end);
    bit_mask = bus.lsb ? (ONE << bit_q) : (TOP >> bit_q);
    out_lsb  = shift_q >> idx_q;
    out_msb  = shift_q << idx_q;
  end
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    rx_d       = rx_q;
    buf_d      = buf_q;
    bit_d      = bit_q;
    idx_d      = idx_q;
    tx_ready_d = tx_ready_q;
    done_d     = 1'b0;
    rx_data_d  = done_q ? rx_q : rx_data_q;
    rx_valid_d = done_q || (rx_valid_q && !bus.rx_ack);
    ovr_d      = done_q && rx_valid_q && !bus.rx_ack;
    if (bus.tx_load && tx_ready_q) begin
      buf_d      = bus.tx_data;
      tx_ready_d = 1'b0;
    end
    if (!active) begin
      if (ss_fall) state_d = ACTIVE;
    end else if (ss_q[1]) begin
      state_d = IDLE;
    end else begin
      if (sample) begin
        rx_d   = mosi_q[1] ? (rx_q | bit_mask) : (rx_q & ~bit_mask);
        bit_d  = bit_q + CNT_W'(1);
        done_d = bit_q == CNT_W'(CHAR_LEN - 1);
      end
      if (trail) idx_d = idx_q + CNT_W'(1);
    end
    // An empty buffer at character start transmits zeros.
    if (start) begin
      shift_d = tx_ready_q ? '0 : buf_q;
      bit_d   = '0;
      idx_d   = '0;
      if (!tx_ready_q) tx_ready_d = 1'b1;
    end
  end
  assign bus.miso_out = active && (bus.lsb ? out_lsb[0] : out_msb[CHAR_LEN-1]);
  assign bus.miso_oe  = active;
  assign bus.busy     = active;
  assign bus.tx_ready = tx_ready_q;
  assign bus.rx_data  = rx_data_q;
  assign bus.rx_valid = rx_valid_q;
  assign bus.overrun  = ovr_q;
endmodule
